// File: rtl/cond_logic_pkg.sv
// Shared condition-code, flag-index and FlagW constants.
// Used by the condition logic, the decoder and the ALU.
package cond_logic_pkg;

  typedef enum logic [3:0] {
    COND_EQ = 4'h0,
    COND_NE = 4'h1,
    COND_CS = 4'h2,
    COND_CC = 4'h3,
    COND_MI = 4'h4,
    COND_PL = 4'h5,
    COND_VS = 4'h6,
    COND_VC = 4'h7,
    COND_HI = 4'h8,
    COND_LS = 4'h9,
    COND_GE = 4'hA,
    COND_LT = 4'hB,
    COND_GT = 4'hC,
    COND_LE = 4'hD,
    COND_AL = 4'hE,
    COND_NV = 4'hF
  } cond_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam int FLAGW_NZ_BIT = 1;
  localparam int FLAGW_CV_BIT = 0;

  localparam logic [1:0] FLAGW_NONE = 2'b00;
  localparam logic [1:0] FLAGW_CV   = 2'b01;
  localparam logic [1:0] FLAGW_NZ   = 2'b10;
  localparam logic [1:0] FLAGW_ALL  = 2'b11;

endpackage

// File: rtl/cond_logic_if.sv
// Decoder <-> condition-logic bundle: condition field, ALU flags,
// raw enables in; gated enables, CondEx and NZCV register out.
interface cond_logic_if;

  logic [3:0] Cond;
  logic [3:0] ALUFlag;
  logic [1:0] FlagW;
  logic       PCS;
  logic       RegW;
  logic       MemW;
  logic       NoWrite;
  logic       CondLatch;
  logic       Stall;
  logic       PCSrc;
  logic       RegWrite;
  logic       MemWrite;
  logic       CondEx;
  logic [3:0] Flags;

  modport master (
    output Cond, ALUFlag, FlagW,
    output PCS, RegW, MemW, NoWrite,
    output CondLatch, Stall,
    input  PCSrc, RegWrite, MemWrite,
    input  CondEx, Flags
  );

  modport slave (
    input  Cond, ALUFlag, FlagW,
    input  PCS, RegW, MemW, NoWrite,
    input  CondLatch, Stall,
    output PCSrc, RegWrite, MemWrite,
    output CondEx, Flags
  );

endinterface

// File: rtl/cond_logic_cond_check.sv
// Pure combinational ARM condition evaluator.
// Ports: cond (Instr[31:28]), flags {N,Z,C,V}, cond_ex (passed).
module cond_check
  import cond_logic_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       cond_ex
);

  logic n, z, c, v, ge;

  always_comb begin
    n  = flags[FLAG_N];
    z  = flags[FLAG_Z];
    c  = flags[FLAG_C];
    v  = flags[FLAG_V];
    ge = (n == v);
    cond_ex = 1'b0;
    unique case (cond)
      COND_EQ: cond_ex = z;
      COND_NE: cond_ex = !z;
      COND_CS: cond_ex = c;
      COND_CC: cond_ex = !c;
      COND_MI: cond_ex = n;
      COND_PL: cond_ex = !n;
      COND_VS: cond_ex = v;
      COND_VC: cond_ex = !v;
      COND_HI: cond_ex = c & !z;
      COND_LS: cond_ex = !c | z;
      COND_GE: cond_ex = ge;
      COND_LT: cond_ex = !ge;
      COND_GT: cond_ex = !z & ge;
      COND_LE: cond_ex = z | !ge;
      COND_AL: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_logic.sv
// NZCV flag register plus condition gating of PC/reg/mem writes.
// Ports: clk, reset_n (async low), bus (cond_logic_if.slave).
module cond_logic
  import cond_logic_pkg::*;
#(
  parameter bit         MULTICYCLE = 1'b0,
  parameter logic [3:0] FLAG_RESET = 4'b0000
) (
  input  logic          clk,
  input  logic          reset_n,
  cond_logic_if.slave   bus
);

  logic [3:0] flags_q, flags_d;
  logic       cond_ex_r_q, cond_ex_r_d;
  logic       dec_ex;
  logic       cond_ex;
  logic       en;

  cond_check u_cond_check (
    .cond    (bus.Cond),
    .flags   (flags_q),
    .cond_ex (dec_ex)
  );

  // Reset gates CondEx so enables drop while reset_n is low,
  // even though the decode of the reset flags may pass.
  always_comb begin
    cond_ex = reset_n & (MULTICYCLE ? cond_ex_r_q : dec_ex);
    en      = cond_ex & ~bus.Stall;
  end

  always_comb begin
    cond_ex_r_d = cond_ex_r_q;
    if (MULTICYCLE && bus.CondLatch && !bus.Stall)
      cond_ex_r_d = dec_ex;
  end

  always_comb begin
    flags_d = flags_q;
    if (en) begin
      if (bus.FlagW[FLAGW_NZ_BIT])
        flags_d[3:2] = bus.ALUFlag[3:2];
      if (bus.FlagW[FLAGW_CV_BIT])
        flags_d[1:0] = bus.ALUFlag[1:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flags_q     <= FLAG_RESET;
      cond_ex_r_q <= 1'b0;
    end else begin
      flags_q     <= flags_d;
      cond_ex_r_q <= cond_ex_r_d;
    end
  end

  assign bus.PCSrc    = bus.PCS & en;
  assign bus.RegWrite = bus.RegW & en & ~bus.NoWrite;
  assign bus.MemWrite = bus.MemW & en;
  assign bus.CondEx   = cond_ex;
  assign bus.Flags    = flags_q;

endmodule

// File: tb/tb_cond_logic.sv
// Self-checking bench: single-cycle and multicycle instances
// driven in parallel, checked against a flag/condition model.
module tb_cond_logic;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] cond, alu;
  logic [1:0] flagw;
  logic       pcs, regw, memw, nowrite, latch, stall;

  int n_checks = 0;
  int n_fail   = 0;

  logic [3:0] m_flags_sc, m_flags_mc;
  logic       m_cexr;

  always #5 clk = ~clk;

  cond_logic_if bus_sc ();
  cond_logic_if bus_mc ();

  assign bus_sc.Cond      = cond;
  assign bus_sc.ALUFlag   = alu;
  assign bus_sc.FlagW     = flagw;
  assign bus_sc.PCS       = pcs;
  assign bus_sc.RegW      = regw;
  assign bus_sc.MemW      = memw;
  assign bus_sc.NoWrite   = nowrite;
  assign bus_sc.CondLatch = latch;
  assign bus_sc.Stall     = stall;
  assign bus_mc.Cond      = cond;
  assign bus_mc.ALUFlag   = alu;
  assign bus_mc.FlagW     = flagw;
  assign bus_mc.PCS       = pcs;
  assign bus_mc.RegW      = regw;
  assign bus_mc.MemW      = memw;
  assign bus_mc.NoWrite   = nowrite;
  assign bus_mc.CondLatch = latch;
  assign bus_mc.Stall     = stall;

  cond_logic #(.MULTICYCLE(1'b0), .FLAG_RESET(4'b0000)) u_sc (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_sc.slave)
  );

  cond_logic #(.MULTICYCLE(1'b1), .FLAG_RESET(4'b0000)) u_mc (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_mc.slave)
  );

  function automatic logic passes(input logic [3:0] c,
                                  input logic [3:0] f);
    bit n = f[3];
    bit z = f[2];
    bit cy = f[1];
    bit v = f[0];
    bit signed_ge = (n == v);
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cy;
      4'd3:  return !cy;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cy && !z;
      4'd9:  return !(cy && !z);
      4'd10: return signed_ge;
      4'd11: return !signed_ge;
      4'd12: return !z && signed_ge;
      4'd13: return !(!z && signed_ge);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] merge(input logic [3:0] old,
                                       input logic [3:0] nw,
                                       input logic [1:0] fw);
    logic [3:0] mask;
    mask = {fw[1], fw[1], fw[0], fw[0]};
    return (old & ~mask) | (nw & mask);
  endfunction

  task automatic model_reset();
    m_flags_sc = 4'b0000;
    m_flags_mc = 4'b0000;
    m_cexr     = 1'b0;
  endtask

  task automatic cycle();
    logic [3:0] nf_sc, nf_mc;
    logic       ncexr, ok_sc;
    ok_sc = passes(cond, m_flags_sc);
    nf_sc = (!stall && ok_sc) ?
            merge(m_flags_sc, alu, flagw) : m_flags_sc;
    nf_mc = (!stall && m_cexr) ?
            merge(m_flags_mc, alu, flagw) : m_flags_mc;
    ncexr = (latch && !stall) ?
            passes(cond, m_flags_mc) : m_cexr;
    @(posedge clk);
    if (reset_n) begin
      m_flags_sc = nf_sc;
      m_flags_mc = nf_mc;
      m_cexr     = ncexr;
    end else begin
      model_reset();
    end
    #1;
  endtask

  task automatic idle();
    cond = 4'hE; alu = 4'h0; flagw = 2'b00;
    pcs = 0; regw = 0; memw = 0; nowrite = 0;
    latch = 0; stall = 0;
  endtask

  task automatic set_sc_flags(input logic [3:0] f);
    idle();
    alu = f; flagw = 2'b11;
    cycle();
    flagw = 2'b00;
  endtask

  task automatic test_reset();
    idle();
    regw = 1'b1;
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (bus_sc.RegWrite !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_regwrite got %b want 0", bus_sc.RegWrite);
    end
    n_checks++;
    if (bus_sc.Flags !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_flags got %b want 0000", bus_sc.Flags);
    end
    n_checks++;
    if (bus_mc.CondEx !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mc_condex got %b want 0", bus_mc.CondEx);
    end
    @(posedge clk);
    #1 reset_n = 1'b1;
    #1;
    n_checks++;
    if (bus_sc.RegWrite !== 1'b1) begin
      n_fail++;
      $display("FAIL release_regwrite got %b want 1",
               bus_sc.RegWrite);
    end
  endtask

  task automatic test_flag_eq();
    set_sc_flags(4'b0100);
    n_checks++;
    if (bus_sc.Flags !== 4'b0100) begin
      n_fail++;
      $display("FAIL flagwr_flags got %b want 0100", bus_sc.Flags);
    end
    cond = 4'h0; regw = 1'b1; #1;
    n_checks++;
    if (bus_sc.RegWrite !== 1'b1) begin
      n_fail++;
      $display("FAIL eq_regwrite got %b want 1", bus_sc.RegWrite);
    end
    cond = 4'h1; #1;
    n_checks++;
    if (bus_sc.RegWrite !== 1'b0) begin
      n_fail++;
      $display("FAIL ne_regwrite got %b want 0", bus_sc.RegWrite);
    end
  endtask

  task automatic test_hazard();
    set_sc_flags(4'b0000);
    cond = 4'h0; flagw = 2'b11; alu = 4'b0100; #1;
    n_checks++;
    if (bus_sc.CondEx !== 1'b0) begin
      n_fail++;
      $display("FAIL hazard_condex got %b want 0", bus_sc.CondEx);
    end
    cycle();
    n_checks++;
    if (bus_sc.Flags !== 4'b0000) begin
      n_fail++;
      $display("FAIL hazard_flags got %b want 0000", bus_sc.Flags);
    end
  endtask

  task automatic test_signed();
    logic [3:0] tf [10];
    logic [3:0] tc [10];
    logic       te [10];
    tf = '{4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b1001,
           4'b1001, 4'b0010, 4'b0110, 4'b0110, 4'b0000};
    tc = '{4'hA, 4'hB, 4'hD, 4'hC, 4'hA,
           4'hC, 4'h8, 4'h9, 4'h8, 4'hF};
    te = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1,
           1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 10; i++) begin
      if (bus_sc.Flags !== tf[i]) set_sc_flags(tf[i]);
      cond = tc[i]; #1;
      n_checks++;
      if (bus_sc.CondEx !== te[i]) begin
        n_fail++;
        $display("FAIL signed_%0d flags %b cond %h got %b want %b",
                 i, tf[i], tc[i], bus_sc.CondEx, te[i]);
      end
    end
  endtask

  task automatic test_cmp();
    idle();
    nowrite = 1; regw = 1; flagw = 2'b11; alu = 4'b1100; #1;
    n_checks++;
    if (bus_sc.RegWrite !== 1'b0) begin
      n_fail++;
      $display("FAIL cmp_regwrite got %b want 0", bus_sc.RegWrite);
    end
    cycle();
    n_checks++;
    if (bus_sc.Flags !== 4'b1100) begin
      n_fail++;
      $display("FAIL cmp_flags got %b want 1100", bus_sc.Flags);
    end
    flagw = 2'b10; alu = 4'b0011;
    cycle();
    n_checks++;
    if (bus_sc.Flags !== 4'b0000) begin
      n_fail++;
      $display("FAIL partial_flags got %b want 0000", bus_sc.Flags);
    end
  endtask

  task automatic test_multicycle();
    idle();
    latch = 1; cycle();
    latch = 0; flagw = 2'b11; alu = 4'b0100; cycle();
    flagw = 2'b00;
    n_checks++;
    if (bus_mc.Flags !== 4'b0100) begin
      n_fail++;
      $display("FAIL mc_flags got %b want 0100", bus_mc.Flags);
    end
    cond = 4'h0; latch = 1; cycle();
    n_checks++;
    if (bus_mc.CondEx !== 1'b1) begin
      n_fail++;
      $display("FAIL mc_latch_eq got %b want 1", bus_mc.CondEx);
    end
    cond = 4'hF; memw = 1; pcs = 1; regw = 1; stall = 1;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_checks++;
      if ({bus_mc.PCSrc, bus_mc.RegWrite, bus_mc.MemWrite,
           bus_mc.CondEx} !== 4'b0001) begin
        n_fail++;
        $display("FAIL mc_stall_%0d got %b want 0001", i,
                 {bus_mc.PCSrc, bus_mc.RegWrite, bus_mc.MemWrite,
                  bus_mc.CondEx});
      end
      cycle();
    end
    stall = 0; latch = 0; pcs = 0; regw = 0; #1;
    n_checks++;
    if (bus_mc.MemWrite !== 1'b1) begin
      n_fail++;
      $display("FAIL mc_unstall_memwrite got %b want 1",
               bus_mc.MemWrite);
    end
    latch = 1; cycle();
    latch = 0; pcs = 1; regw = 1;
    #1;
    n_checks++;
    if ({bus_mc.PCSrc, bus_mc.RegWrite, bus_mc.MemWrite,
         bus_mc.CondEx} !== 4'b0000) begin
      n_fail++;
      $display("FAIL mc_nv got %b want 0000",
               {bus_mc.PCSrc, bus_mc.RegWrite, bus_mc.MemWrite,
                bus_mc.CondEx});
    end
  endtask

  task automatic test_reset_mid();
    set_sc_flags(4'b1011);
    flagw = 2'b11; alu = 4'b0100; regw = 1; memw = 1;
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if ({bus_sc.Flags, bus_sc.RegWrite, bus_sc.MemWrite}
        !== 6'b000000) begin
      n_fail++;
      $display("FAIL reset_mid got %b want 000000",
               {bus_sc.Flags, bus_sc.RegWrite, bus_sc.MemWrite});
    end
    cycle();
    reset_n = 1'b1;
    idle();
    #1;
  endtask

  task automatic test_random();
    logic [7:0] exp_sc, exp_mc, got_sc, got_mc;
    logic       cs, cm;
    for (int i = 0; i < 400; i++) begin
      cond    = 4'($urandom_range(0, 15));
      alu     = 4'($urandom_range(0, 15));
      flagw   = 2'($urandom_range(0, 3));
      pcs     = 1'($urandom_range(0, 1));
      regw    = 1'($urandom_range(0, 1));
      memw    = 1'($urandom_range(0, 1));
      nowrite = 1'($urandom_range(0, 1));
      latch   = 1'($urandom_range(0, 1));
      stall   = ($urandom_range(0, 3) == 0);
      #1;
      cs = passes(cond, m_flags_sc);
      cm = m_cexr;
      exp_sc = {pcs && cs && !stall,
                regw && cs && !stall && !nowrite,
                memw && cs && !stall, cs, m_flags_sc};
      exp_mc = {pcs && cm && !stall,
                regw && cm && !stall && !nowrite,
                memw && cm && !stall, cm, m_flags_mc};
      got_sc = {bus_sc.PCSrc, bus_sc.RegWrite, bus_sc.MemWrite,
                bus_sc.CondEx, bus_sc.Flags};
      got_mc = {bus_mc.PCSrc, bus_mc.RegWrite, bus_mc.MemWrite,
                bus_mc.CondEx, bus_mc.Flags};
      n_checks++;
      if (got_sc !== exp_sc) begin
        n_fail++;
        $display("FAIL rand_sc_%0d got %b want %b", i, got_sc, exp_sc);
      end
      n_checks++;
      if (got_mc !== exp_mc) begin
        n_fail++;
        $display("FAIL rand_mc_%0d got %b want %b", i, got_mc, exp_mc);
      end
      cycle();
    end
  endtask

  initial begin
    test_reset();
    test_flag_eq();
    test_hazard();
    test_signed();
    test_cmp();
    test_multicycle();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cond_logic.md
Name: cond_logic

Overview:
- Consumer end of the ALU flag interface: holds the architectural NZCV flag register and evaluates the 4-bit ARM condition field of each instruction against it.
- Gates the decoder's write enables (PC, register file, memory) with the condition result.
- Sits between the main decoder/control FSM and the datapath, fed by the ALU's 4-bit {N,Z,C,V} flag bus.
- Supports single-cycle use (condition combinational) and multicycle use (condition latched at decode and held through execute/writeback).

Parameters:
- MULTICYCLE, 0. 0 = CondEx used combinationally; 1 = CondEx captured on CondLatch and held in a register.
- FLAG_RESET, 4'b0000. Reset value of the NZCV register.

Ports:
- clk  input  1  system clock, rising-edge.
- reset_n  input  1  asynchronous, active-low reset.
- Cond  input  4  instruction condition field, Instr[31:28].
- ALUFlag  input  4  {N,Z,C,V} from the ALU, current cycle. C follows ARM convention: 1 = carry out / no borrow.
- FlagW  input  2  [1] = update N,Z; [0] = update C,V.
- PCS  input  1  decoder: instruction writes PC.
- RegW  input  1  decoder: instruction writes register file.
- MemW  input  1  decoder: instruction writes memory.
- NoWrite  input  1  compare-class instruction; suppresses the register write.
- CondLatch  input  1  multicycle only: capture CondEx this cycle (decode state). Ignored when MULTICYCLE=0.
- Stall  input  1  freeze: no state update, all enables forced low.
- PCSrc  output  1  gated PC write / branch select.
- RegWrite  output  1  gated register-file write enable.
- MemWrite  output  1  gated memory write enable.
- CondEx  output  1  effective condition-passed value used for gating.
- Flags  output  4  current registered {N,Z,C,V}.

Behaviour:
- Reset (reset_n=0, asynchronous): Flags=FLAG_RESET; CondExR=0. While reset_n=0, PCSrc, RegWrite, MemWrite and CondEx are all 0.
- Condition decode uses the registered Flags, never ALUFlag directly:
  - EQ 0000 Z; NE 0001 !Z; CS 0010 C; CC 0011 !C; MI 0100 N; PL 0101 !N; VS 0110 V; VC 0111 !V.
  - HI 1000 C&!Z; LS 1001 !C|Z; GE 1010 N==V; LT 1011 N!=V; GT 1100 !Z&(N==V); LE 1101 Z|(N!=V); AL 1110 1.
  - 1111 → 0 (never execute).
- Effective CondEx:
  - MULTICYCLE=0: combinational decode.
  - MULTICYCLE=1: CondExR, loaded with the decode result on the clk edge where CondLatch=1 and Stall=0, held otherwise.
- Outputs (combinational from CondEx, all forced 0 when Stall=1):
  - PCSrc = PCS & CondEx.
  - RegWrite = RegW & CondEx & ~NoWrite.
  - MemWrite = MemW & CondEx.
- Flag register update at clk edge when Stall=0 and CondEx=1:
  - FlagW[1] → Flags[3:2] <= ALUFlag[3:2].
  - FlagW[0] → Flags[1:0] <= ALUFlag[1:0].
  - FlagW=00 or CondEx=0 → hold.
- Latency:
  - New flags become visible to condition decode one cycle after the write.
  - An instruction writing flags in cycle t is evaluated against the pre-write flags in cycle t.
- Simultaneous events:
  - Stall+CondLatch: Stall wins, CondExR holds.
  - CondLatch+flag write in the same cycle: CondExR captures the decode of the old Flags.
- Reset mid-instruction: Flags and CondExR clear immediately, enables drop in the same cycle, no partial flag write.
- A condition-failed instruction never updates flags, even with FlagW=11.

Decomposition:
- Shared package holds the condition-code constants (COND_EQ … COND_AL, COND_NV), flag bit indices (FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0) and FlagW encodings, shared with the decoder and the ALU.
- One sub-module: cond_check, pure combinational (Cond, Flags) → CondEx, reusable by a future branch predictor.

Test Plan:
- Reset: reset_n=0 with Cond=AL, RegW=1 → RegWrite=0, Flags=0000. Release → RegWrite=1 next evaluation.
- Flag write then EQ: ALUFlag=0100, FlagW=11, Cond=AL → Flags=0100 after edge. Next cycle Cond=EQ, RegW=1 → RegWrite=1. Cond=NE → 0.
- Same-cycle hazard: Flags=0000, FlagW=11, ALUFlag=0100, Cond=EQ → CondEx=0, flags not written, Flags stays 0000.
- Signed compares: Flags=1000 → GE=0, LT=1, LE=1, GT=0. Flags=1001 → GE=1, GT=1. Flags=0010 → HI=1. Flags=0110 → LS=1.
- CMP/partial update: NoWrite=1, RegW=1, Cond=AL, FlagW=11 → RegWrite=0, flags updated. FlagW=10 with ALUFlag=0011 from Flags=1100 → Flags=0000.
- MULTICYCLE=1: CondLatch with Cond=EQ, Flags Z=1 → CondExR=1. Then Stall=1 for 2 cycles → all enables 0, CondExR held. Stall=0 → MemWrite=MemW. Cond=1111 latched → all enables 0.
